// File: rtl/h_mux16_arbiter.sv
// h_mux16_arbiter: round-robin arbiter sharing one 16-bit datapath between
// two valid/ready requesters (A and B). A grant is held for a whole burst,
// ended by last_x. The grant steers the select of an h_mux16 instance.
//
// Optional feature: define H_ARB_BURST_LIMIT_EN to also end a burst after
// MAX_BURST beats, bounding the wait of the other requester.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset
//   req_a / req_b    requester has a beat available
//   data_a / data_b  requester beat data (16 bits)
//   last_a / last_b  current beat is the final beat of the burst
//   gnt_a / gnt_b    registered grants
//   sel              registered mux select (0 = A, 1 = B)
//   out_valid        downstream valid (granted side is requesting)
//   out_data         selected beat data (combinational)
//   out_ready        downstream accepts the beat this cycle

// 16-bit two-way mux: sel = 0 passes a, sel = 1 passes b.
module h_mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] out
);
    assign out = sel ? b : a;
endmodule

module h_mux16_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic        last_a,
    input  logic        last_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        sel,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_A = 2'd1;
    localparam logic [1:0] GRANT_B = 2'd2;

    // A burst counter of clog2(MAX_BURST) bits needs at least two beats.
    if (MAX_BURST < 2) begin : g_bad_max_burst
        $error("h_mux16_arbiter: MAX_BURST must be at least 2");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       prio;
    logic       prio_nxt;
    logic       beat_a;
    logic       beat_b;
    logic       end_a;
    logic       end_b;

    // Winner of the current requests given a priority pointer.
    function automatic logic [1:0] arbitrate(input logic ra, input logic rb,
                                             input logic p);
        if (ra && rb) return p ? GRANT_B : GRANT_A;
        if (ra)       return GRANT_A;
        if (rb)       return GRANT_B;
        return IDLE;
    endfunction

    assign beat_a = (state == GRANT_A) & req_a & out_ready;
    assign beat_b = (state == GRANT_B) & req_b & out_ready;

`ifdef H_ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST);

    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic             at_limit;

    // The beat being accepted now is beat number MAX_BURST of this grant.
    assign at_limit = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign end_a    = beat_a & (last_a | at_limit);
    assign end_b    = beat_b & (last_b | at_limit);
`else
    assign end_a    = beat_a & last_a;
    assign end_b    = beat_b & last_b;
`endif

    // Next-state, priority and burst-counter logic.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
`ifdef H_ARB_BURST_LIMIT_EN
        beat_cnt_nxt = beat_cnt;
`endif
        case (state)
            IDLE: begin
                state_nxt = arbitrate(req_a, req_b, prio);
`ifdef H_ARB_BURST_LIMIT_EN
                beat_cnt_nxt = '0;
`endif
            end
            GRANT_A: begin
                if (end_a) begin
                    // Hand priority to B before re-arbitrating.
                    prio_nxt  = 1'b1;
                    state_nxt = arbitrate(req_a, req_b, 1'b1);
`ifdef H_ARB_BURST_LIMIT_EN
                    beat_cnt_nxt = '0;
                end else if (beat_a) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
`endif
                end
            end
            GRANT_B: begin
                if (end_b) begin
                    prio_nxt  = 1'b0;
                    state_nxt = arbitrate(req_a, req_b, 1'b0);
`ifdef H_ARB_BURST_LIMIT_EN
                    beat_cnt_nxt = '0;
                end else if (beat_b) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, priority and registered grant/select outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prio  <= 1'b0;
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            sel   <= 1'b0;
`ifdef H_ARB_BURST_LIMIT_EN
            beat_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            gnt_a <= (state_nxt == GRANT_A);
            gnt_b <= (state_nxt == GRANT_B);
            // Select only moves when a new grant is issued; IDLE keeps it.
            if (state_nxt == GRANT_A) begin
                sel <= 1'b0;
            end else if (state_nxt == GRANT_B) begin
                sel <= 1'b1;
            end
`ifdef H_ARB_BURST_LIMIT_EN
            beat_cnt <= beat_cnt_nxt;
`endif
        end
    end

    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);

    h_mux16 u_mux (
        .a   (data_a),
        .b   (data_b),
        .sel (sel),
        .out (out_data)
    );

endmodule

// File: tb/tb_h_mux16_arbiter.sv
// Testbench for h_mux16_arbiter. Stimulus pushes each expected accepted beat
// ({sel, data}) into a queue; a monitor pops and compares on every accepted
// beat. Grant/select/valid are also checked cycle by cycle.
module tb_h_mux16_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] data_a = 16'h0;
    logic [15:0] data_b = 16'h0;
    logic        last_a = 1'b0;
    logic        last_b = 1'b0;
    logic        out_ready = 1'b1;
    logic        gnt_a;
    logic        gnt_b;
    logic        sel;
    logic        out_valid;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_exp;

    h_mux16_arbiter #(.MAX_BURST(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .last_a    (last_a),
        .last_b    (last_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got sel=%0d data=%h, required no beat",
                         sel, out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({sel, out_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL beat: got sel=%0d data=%h, required sel=%0d data=%h",
                             sel, out_data, mon_exp[16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk_gnt(input string nm, input logic ea, input logic eb,
                           input logic es, input logic ev);
        chk({nm, ".gnt_a"},     16'(gnt_a),     16'(ea));
        chk({nm, ".gnt_b"},     16'(gnt_b),     16'(eb));
        chk({nm, ".sel"},       16'(sel),       16'(es));
        chk({nm, ".out_valid"}, 16'(out_valid), 16'(ev));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input logic s, input logic [15:0] d);
        exp_q.push_back({s, d});
    endtask

    // Two reset cycles; outputs must be at reset values during the second.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        last_a = 1'b0; last_b = 1'b0; out_ready = 1'b1;
        next_cycle();
        sample();
        chk_gnt("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset, single request
        do_reset();
        next_cycle();
        reset = 1'b0; req_a = 1'b1; data_a = 16'h1234; last_a = 1'b1;
        sample(); chk_gnt("single_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle(); push(1'b0, 16'h1234);
        sample(); chk_gnt("single_c1", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("single_c1.out_data", out_data, 16'h1234);
        // A still requested during its ending beat, B idle: A is re-granted.
        next_cycle(); req_a = 1'b0;
        sample(); chk_gnt("single_c2", 1'b1, 1'b0, 1'b0, 1'b0);

        // Contention and round-robin
        do_reset();
        next_cycle();
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b1;
        data_a = 16'hA001; data_b = 16'hB001;
        sample(); chk_gnt("rr_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle(); push(1'b0, 16'hA001);
        sample(); chk_gnt("rr_c1", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle(); push(1'b1, 16'hB001);
        sample(); chk_gnt("rr_c2", 1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle(); data_a = 16'hA002; data_b = 16'hB002; push(1'b0, 16'hA002);
        sample(); chk_gnt("rr_c3", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle(); push(1'b1, 16'hB002);
        sample(); chk_gnt("rr_c4", 1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle(); req_a = 1'b0; req_b = 1'b0;
        sample(); chk_gnt("rr_c5", 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure on B
        do_reset();
        next_cycle();
        reset = 1'b0; req_b = 1'b1; last_b = 1'b1; data_b = 16'hBEEF; out_ready = 1'b0;
        sample(); chk_gnt("bp_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            sample(); chk_gnt($sformatf("bp_c%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
            chk($sformatf("bp_c%0d.out_data", i), out_data, 16'hBEEF);
        end
        next_cycle(); out_ready = 1'b1; push(1'b1, 16'hBEEF);
        sample(); chk_gnt("bp_c4", 1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle(); req_b = 1'b0;
        sample(); chk_gnt("bp_c5", 1'b0, 1'b1, 1'b1, 1'b0);

        // Multi-beat A burst with B competing
        do_reset();
        next_cycle();
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b1;
        data_a = 16'hE000; data_b = 16'hF00F;
        sample(); chk_gnt("mb_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            data_a = 16'hE000 + 16'(i);
            last_a = (i == 4);
            push(1'b0, data_a);
            sample(); chk_gnt($sformatf("mb_a%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        next_cycle(); req_a = 1'b0; last_a = 1'b0; push(1'b1, 16'hF00F);
        sample(); chk_gnt("mb_b", 1'b0, 1'b1, 1'b1, 1'b1);
        next_cycle(); req_b = 1'b0;
        sample(); chk_gnt("mb_hold", 1'b0, 1'b1, 1'b1, 1'b0);

        // Burst limit: last_a never asserted, B waiting
        do_reset();
        next_cycle();
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b1;
        data_a = 16'hA5A5; data_b = 16'hB5B5;
        sample(); chk_gnt("lim_c0", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef H_ARB_BURST_LIMIT_EN
        for (int i = 1; i <= 8; i++) begin
            next_cycle(); push(1'b0, 16'hA5A5);
            sample(); chk_gnt($sformatf("lim_a%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        next_cycle(); push(1'b1, 16'hB5B5);
        sample(); chk_gnt("lim_b", 1'b0, 1'b1, 1'b1, 1'b1);
`else
        for (int i = 1; i <= 12; i++) begin
            next_cycle(); push(1'b0, 16'hA5A5);
            sample(); chk_gnt($sformatf("lim_a%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
`endif
        next_cycle(); req_a = 1'b0; req_b = 1'b0;
        sample();

        // Reset mid-burst, after A has moved the priority pointer to B
        do_reset();
        next_cycle();
        reset = 1'b0; req_a = 1'b1; last_a = 1'b1; data_a = 16'hC001;
        sample(); chk_gnt("rst_c0", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle(); push(1'b0, 16'hC001);
        sample(); chk_gnt("rst_c1", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle(); last_a = 1'b0; data_a = 16'hC002; push(1'b0, 16'hC002);
        sample(); chk_gnt("rst_c2", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle(); data_a = 16'hC003; reset = 1'b1; push(1'b0, 16'hC003);
        sample(); chk_gnt("rst_c3", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b1;
        data_a = 16'hC004; data_b = 16'hD004;
        sample(); chk_gnt("rst_c4", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle(); push(1'b0, 16'hC004);
        sample(); chk_gnt("rst_c5", 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle(); req_a = 1'b0; req_b = 1'b0;
        sample(); chk_gnt("rst_c6", 1'b0, 1'b1, 1'b1, 1'b0);

        // All expected beats must have been consumed by the monitor.
        next_cycle();
        sample();
        chk("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
